// File: rtl/bam8_err_monitor.sv
`default_nettype none
// ============================================================================
// bam8_err_monitor : windowed error statistics for the 8x8 approximate multiplier
// Rev 1.0
// ============================================================================
module bam8_err_monitor #(
  parameter int N     = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   win_len_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [N-1:0]       a_i,
  input  logic [N-1:0]       b_i,
  input  logic [2*N-1:0]     p_apx_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ACC_W-1:0]   err_sum_o,
  output logic [2*N-1:0]     err_max_o,
  output logic [CNT_W-1:0]   err_cnt_o,
  output logic               busy_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2*N-1:0]   e_q;
  logic             e_v_q;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [2*N-1:0]   max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             w_accept;
  logic             w_open;
  logic [2*N-1:0]   w_prod;
  logic [2*N-1:0]   w_err;
  logic [ACC_W:0]   w_sum_wide;

  assign w_accept = (state_q == S_RUN) && in_valid_i;
  assign w_open   = (state_q == S_IDLE) && start_i && (win_len_i != '0);

  assign w_prod = {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i};
  assign w_err  = (w_prod >= p_apx_i) ? (w_prod - p_apx_i) : (p_apx_i - w_prod);

  // One extra bit catches the carry so the sum can clamp instead of wrapping.
  assign w_sum_wide = {1'b0, sum_q} + {{(ACC_W+1-2*N){1'b0}}, e_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (w_open) begin
          state_d = S_RUN;
          rem_d   = win_len_i;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN:  state_d = S_REPORT;
      S_REPORT: if (out_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sum_d = sum_q;
    max_d = max_q;
    cnt_d = cnt_q;
    if (w_open) begin
      sum_d = '0;
      max_d = '0;
      cnt_d = '0;
    end else if (e_v_q) begin
      sum_d = w_sum_wide[ACC_W] ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];
      max_d = (e_q > max_q) ? e_q : max_q;
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, (e_q != '0)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      e_q     <= '0;
      e_v_q   <= 1'b0;
      sum_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      e_v_q   <= w_accept;
      if (w_accept) e_q <= w_err;
      sum_q   <= sum_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o  = (state_q == S_RUN);
  assign out_valid_o = (state_q == S_REPORT);
  assign busy_o      = (state_q != S_IDLE);
  assign err_sum_o   = sum_q;
  assign err_max_o   = max_q;
  assign err_cnt_o   = cnt_q;

endmodule
`default_nettype wire
